dht11_frame_checker: RTL and testbench

//   Downstream stage of the DHT11 reader. Captures one 5-byte reading (hum int/frac,

---
 rtl/dht11_pkg.sv | 23 ++
 rtl/bin2bcd8.sv | 62 ++++++
 rtl/dht11_frame_checker.sv | 200 ++++++++++++++++++++
 tb/tb_dht11_frame_checker.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/dht11_pkg.sv
// rtl/dht11_pkg.sv - shared types and widths for the DHT11 frame checker
//
// Purpose: FSM state encoding and datapath widths used by the frame checker
// and its serial BCD converter.
// Contents:
//   BYTE_W     width of one sensor byte
//   BCD_W      width of a 3-digit BCD result
//   CONV_STEPS shift-add-3 steps per conversion (one per binary bit)
//   state_e    2-bit FSM state encoding
package dht11_pkg;

  localparam int BYTE_W     = 8;
  localparam int BCD_W      = 12;
  localparam int CONV_STEPS = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_CONV  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/bin2bcd8.sv
// rtl/bin2bcd8.sv - serial 8-bit binary to 3-digit BCD converter
//
// Purpose: shift-add-3 converter advanced one step per cycle by the parent.
// Ports:
//   clk     in   system clock
//   rst     in   synchronous active-high reset
//   load    in   capture bin and clear the BCD accumulator
//   step    in   perform one shift-add-3 step (ignored while load is high)
//   bin     in   8-bit binary value to convert
//   result  out  12-bit BCD {hundreds,tens,units}; valid after 8 steps
module bin2bcd8
  import dht11_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [BYTE_W-1:0] bin,
  output logic [BCD_W-1:0]  result
);

  logic [BYTE_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic [BCD_W-1:0]  adj;
  logic              unused_carry;

  always_comb begin
    // Nibbles >= 5 would reach >= 10 after the shift; +3 makes them carry.
    adj = bcd_q;
    for (int n = 0; n < 3; n++) begin
      if (bcd_q[4*n +: 4] >= 4'd5) begin
        adj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
      end
    end

    bin_d        = bin_q;
    bcd_d        = bcd_q;
    unused_carry = 1'b0;
    if (load) begin
      bin_d = bin;
      bcd_d = '0;
    end else if (step) begin
      // Hundreds digit never exceeds 2 for an 8-bit input, so the bit
      // shifted out of the top is always zero.
      {unused_carry, bcd_d} = {adj, bin_q[BYTE_W-1]};
      bin_d                 = {bin_q[BYTE_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q <= '0;
      bcd_q <= '0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
    end
  end

  assign result = bcd_q;

endmodule

// File: rtl/dht11_frame_checker.sv
// rtl/dht11_frame_checker.sv - DHT11 reading checksum check and BCD conversion
//
// Purpose: captures a 5-byte DHT11 reading, verifies its checksum, converts
// the integer humidity/temperature bytes to BCD and holds the last good
// reading for the display stage.
// Optional feature macro: DHT11_RANGE_CHECK_EN (rejects readings whose
// integer humidity exceeds HUM_MAX or integer temperature exceeds TEMP_MAX).
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   frame_valid  in   1-cycle pulse, byte inputs hold a complete reading
//   hum_i/hum_f  in   humidity integer/fraction bytes
//   temp_i/temp_f in  temperature integer/fraction bytes
//   par          in   checksum byte from the sensor
//   hum_bcd      out  last good humidity, BCD
//   temp_bcd     out  last good temperature, BCD
//   out_valid    out  1-cycle pulse when the BCD outputs update
//   crc_err      out  1-cycle pulse when a reading is rejected
//   overrun      out  1-cycle pulse when a reading arrives while busy
//   busy         out  high whenever the FSM is not idle
//   err_count    out  saturating count of rejected readings
module dht11_frame_checker
  import dht11_pkg::*;
#(
  parameter logic [BYTE_W-1:0] HUM_MAX  = 8'd90,
  parameter logic [BYTE_W-1:0] TEMP_MAX = 8'd50
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_valid,
  input  logic [BYTE_W-1:0] hum_i,
  input  logic [BYTE_W-1:0] hum_f,
  input  logic [BYTE_W-1:0] temp_i,
  input  logic [BYTE_W-1:0] temp_f,
  input  logic [BYTE_W-1:0] par,
  output logic [BCD_W-1:0]  hum_bcd,
  output logic [BCD_W-1:0]  temp_bcd,
  output logic              out_valid,
  output logic              crc_err,
  output logic              overrun,
  output logic              busy,
  output logic [7:0]        err_count
);

  state_e            state_q, state_d;
  logic [BYTE_W-1:0] hum_i_q, hum_i_d, hum_f_q, hum_f_d;
  logic [BYTE_W-1:0] temp_i_q, temp_i_d, temp_f_q, temp_f_d;
  logic [BYTE_W-1:0] par_q, par_d;
  logic [2:0]        iter_q, iter_d;
  logic              reject_q, reject_d;
  logic [BCD_W-1:0]  hum_bcd_q, hum_bcd_d, temp_bcd_q, temp_bcd_d;
  logic              out_valid_q, out_valid_d;
  logic              crc_err_q, crc_err_d;
  logic              overrun_q, overrun_d;
  logic [7:0]        err_count_q, err_count_d;

  logic              conv_load, conv_step;
  logic [BCD_W-1:0]  hum_res, temp_res;
  logic [BYTE_W-1:0] sum;
  logic              range_bad;

`ifdef DHT11_RANGE_CHECK_EN
  assign range_bad = (hum_i_q > HUM_MAX) || (temp_i_q > TEMP_MAX);
`else
  logic unused_range_cfg;
  assign range_bad        = 1'b0;
  assign unused_range_cfg = ^{HUM_MAX, TEMP_MAX};
`endif

  // Checksum is the low byte of the sum of the four data bytes.
  assign sum = hum_i_q + hum_f_q + temp_i_q + temp_f_q;

  always_comb begin
    state_d     = state_q;
    hum_i_d     = hum_i_q;
    hum_f_d     = hum_f_q;
    temp_i_d    = temp_i_q;
    temp_f_d    = temp_f_q;
    par_d       = par_q;
    iter_d      = iter_q;
    reject_d    = 1'b0;
    hum_bcd_d   = hum_bcd_q;
    temp_bcd_d  = temp_bcd_q;
    out_valid_d = 1'b0;
    crc_err_d   = 1'b0;
    err_count_d = err_count_q;
    conv_load   = 1'b0;
    conv_step   = 1'b0;

    // A reading arriving mid-flight is dropped; the current one continues.
    overrun_d = frame_valid && (state_q != ST_IDLE);

    // Rejection is flagged on the CHECK exit and reported one cycle later,
    // so the FSM is already idle when crc_err pulses.
    if (reject_q) begin
      crc_err_d = 1'b1;
      if (err_count_q != 8'hFF) begin
        err_count_d = err_count_q + 8'd1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (frame_valid) begin
          hum_i_d  = hum_i;
          hum_f_d  = hum_f;
          temp_i_d = temp_i;
          temp_f_d = temp_f;
          par_d    = par;
          state_d  = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if ((sum != par_q) || range_bad) begin
          reject_d = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          conv_load = 1'b1;
          iter_d    = 3'd0;
          state_d   = ST_CONV;
        end
      end
      ST_CONV: begin
        conv_step = 1'b1;
        iter_d    = iter_q + 3'd1;
        if (iter_q == 3'(CONV_STEPS - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        hum_bcd_d   = hum_res;
        temp_bcd_d  = temp_res;
        out_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hum_i_q     <= '0;
      hum_f_q     <= '0;
      temp_i_q    <= '0;
      temp_f_q    <= '0;
      par_q       <= '0;
      iter_q      <= '0;
      reject_q    <= 1'b0;
      hum_bcd_q   <= '0;
      temp_bcd_q  <= '0;
      out_valid_q <= 1'b0;
      crc_err_q   <= 1'b0;
      overrun_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      hum_i_q     <= hum_i_d;
      hum_f_q     <= hum_f_d;
      temp_i_q    <= temp_i_d;
      temp_f_q    <= temp_f_d;
      par_q       <= par_d;
      iter_q      <= iter_d;
      reject_q    <= reject_d;
      hum_bcd_q   <= hum_bcd_d;
      temp_bcd_q  <= temp_bcd_d;
      out_valid_q <= out_valid_d;
      crc_err_q   <= crc_err_d;
      overrun_q   <= overrun_d;
      err_count_q <= err_count_d;
    end
  end

  bin2bcd8 u_hum_conv (
    .clk    (clk),
    .rst    (rst),
    .load   (conv_load),
    .step   (conv_step),
    .bin    (hum_i_q),
    .result (hum_res)
  );

  bin2bcd8 u_temp_conv (
    .clk    (clk),
    .rst    (rst),
    .load   (conv_load),
    .step   (conv_step),
    .bin    (temp_i_q),
    .result (temp_res)
  );

  assign hum_bcd   = hum_bcd_q;
  assign temp_bcd  = temp_bcd_q;
  assign out_valid = out_valid_q;
  assign crc_err   = crc_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != ST_IDLE);
  assign err_count = err_count_q;

endmodule

// File: tb/tb_dht11_frame_checker.sv
// tb/tb_dht11_frame_checker.sv - self-checking bench for dht11_frame_checker
module tb_dht11_frame_checker;

`ifdef DHT11_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_valid;
  logic [7:0]  hum_i, hum_f, temp_i, temp_f, par;
  logic [11:0] hum_bcd, temp_bcd;
  logic        out_valid, crc_err, overrun, busy;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;

  logic [11:0] held_h = 12'h000;
  logic [11:0] held_t = 12'h000;
  int          exp_err = 0;

  typedef struct {
    logic [7:0]  h, hf, t, tf, p;
    bit          ok;
    logic [11:0] eh, et;
  } vec_t;
  vec_t tbl[4];

  dht11_frame_checker dut (
    .clk         (clk),
    .rst         (rst),
    .frame_valid (frame_valid),
    .hum_i       (hum_i),
    .hum_f       (hum_f),
    .temp_i      (temp_i),
    .temp_f      (temp_f),
    .par         (par),
    .hum_bcd     (hum_bcd),
    .temp_bcd    (temp_bcd),
    .out_valid   (out_valid),
    .crc_err     (crc_err),
    .overrun     (overrun),
    .busy        (busy),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic bit accept(input int h, input int hf, input int t, input int tf, input int p);
    bit sum_ok;
    sum_ok = ((h + hf + t + tf) % 256) == p;
    return sum_ok && (!RC || (h <= 90 && t <= 50));
  endfunction

  task automatic drive(input logic [7:0] h, hf, t, tf, p);
    hum_i = h; hum_f = hf; temp_i = t; temp_f = tf; par = p;
    frame_valid = 1'b1;
  endtask

  // Called at the negedge following the frame's sampling edge; k counts
  // edges after that sampling edge until out_valid or crc_err is seen.
  task automatic wait_event(output int k);
    bit seen;
    k = 0;
    seen = 0;
    while (!seen && k < 20) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (out_valid || crc_err) seen = 1;
    end
  endtask

  task automatic run_frame(input logic [7:0] h, hf, t, tf, p, input bit ok,
                           input logic [11:0] eh, et);
    int k;
    drive(h, hf, t, tf, p);
    @(posedge clk);
    @(negedge clk);
    frame_valid = 1'b0;
    wait_event(k);
    chk("latency", k, ok ? 10 : 2);
    if (ok) begin
      held_h = eh;
      held_t = et;
      chk("out_valid", out_valid, 1);
      chk("crc_err_on_good", crc_err, 0);
    end else begin
      if (exp_err < 255) exp_err++;
      chk("crc_err", crc_err, 1);
      chk("out_valid_on_bad", out_valid, 0);
    end
    chk("err_count", err_count, exp_err);
    chk("hum_bcd", hum_bcd, held_h);
    chk("temp_bcd", temp_bcd, held_t);
    @(posedge clk);
    @(negedge clk);
    chk("pulses_low", {out_valid, crc_err, overrun}, 0);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    int k;
    bit flag;
    logic [7:0] h, hf, t, tf, p;

    tbl[0] = '{8'd55,  8'd0,   8'd25, 8'd0, 8'd80, 1'b1, 12'h055, 12'h025};
    tbl[1] = '{8'd60,  8'd0,   8'd20, 8'd0, 8'd81, 1'b0, 12'h000, 12'h000};
    tbl[2] = '{8'd200, 8'd100, 8'd0,  8'd0, 8'd44, !RC,  12'h200, 12'h000};
    tbl[3] = '{8'd255, 8'd0,   8'd99, 8'd0, 8'd98, !RC,  12'h255, 12'h099};

    rst = 1'b1;
    frame_valid = 1'b0;
    hum_i = '0; hum_f = '0; temp_i = '0; temp_f = '0; par = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_hum_bcd", hum_bcd, 0);
    chk("rst_temp_bcd", temp_bcd, 0);
    chk("rst_pulses", {out_valid, crc_err, overrun}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_count", err_count, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      run_frame(tbl[i].h, tbl[i].hf, tbl[i].t, tbl[i].tf, tbl[i].p,
                tbl[i].ok, tbl[i].eh, tbl[i].et);
    end

    // Back-to-back: second reading in the cycle right after out_valid.
    drive(8'd12, 8'd3, 8'd34, 8'd5, 8'd54);
    @(posedge clk);
    @(negedge clk);
    frame_valid = 1'b0;
    wait_event(k);
    chk("b2b_a_latency", k, 10);
    chk("b2b_a_hum", hum_bcd, 12'h012);
    chk("b2b_a_temp", temp_bcd, 12'h034);
    drive(8'd87, 8'd1, 8'd49, 8'd2, 8'd139);
    @(posedge clk);
    @(negedge clk);
    frame_valid = 1'b0;
    chk("b2b_b_busy", busy, 1);
    chk("b2b_b_no_overrun", overrun, 0);
    wait_event(k);
    chk("b2b_b_latency", k, 10);
    chk("b2b_b_hum", hum_bcd, 12'h087);
    chk("b2b_b_temp", temp_bcd, 12'h049);
    @(negedge clk);

    // Overrun: second reading 3 cycles after an accepted one is dropped.
    drive(8'd42, 8'd0, 8'd17, 8'd0, 8'd59);
    @(posedge clk);
    @(negedge clk);
    frame_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    drive(8'd1, 8'd2, 8'd3, 8'd4, 8'd10);
    @(posedge clk);
    @(negedge clk);
    frame_valid = 1'b0;
    chk("overrun_pulse", overrun, 1);
    chk("overrun_busy", busy, 1);
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("overrun_out_valid", out_valid, 1);
    chk("overrun_hum", hum_bcd, 12'h042);
    chk("overrun_temp", temp_bcd, 12'h017);
    @(posedge clk);
    @(negedge clk);
    chk("overrun_dropped", {out_valid, overrun, busy}, 0);

    // Reset during conversion discards the in-flight reading.
    drive(8'd30, 8'd0, 8'd20, 8'd0, 8'd50);
    @(posedge clk);
    @(negedge clk);
    frame_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_bcd", {hum_bcd, temp_bcd}, 0);
    chk("midrst_pulses", {out_valid, crc_err, overrun}, 0);
    chk("midrst_err_count", err_count, 0);
    rst = 1'b0;
    held_h = 12'h000;
    held_t = 12'h000;
    exp_err = 0;
    flag = 0;
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) flag = 1;
    end
    chk("midrst_no_result", flag, 0);

    for (int i = 0; i < 40; i++) begin
      h  = 8'($urandom_range(0, 255));
      hf = 8'($urandom_range(0, 255));
      t  = 8'($urandom_range(0, 255));
      tf = 8'($urandom_range(0, 255));
      p  = 8'((int'(h) + int'(hf) + int'(t) + int'(tf)) % 256);
      if ($urandom_range(0, 3) == 0) p = 8'(int'(p) + $urandom_range(1, 255));
      run_frame(h, hf, t, tf, p, accept(h, hf, t, tf, p), to_bcd(h), to_bcd(t));
    end

    for (int i = 0; i < 300; i++) begin
      h  = 8'($urandom_range(0, 255));
      t  = 8'($urandom_range(0, 255));
      p  = 8'(int'(h) + int'(t) + 1);
      run_frame(h, 8'd0, t, 8'd0, p, 1'b0, 12'h000, 12'h000);
    end
    chk("err_count_saturated", err_count, 255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
